uart_frame_decoder: RTL and testbench
=====================================

Name: uart_frame_decoder

Overview:
Receive-side framing stage that sits directly downstream of uart_rx. It consumes the uart_rx byte stream (rx_data_ready/rx_data), hunts for the 4-byte magic word, and collects PAYLOAD_BYTES payload bytes plus a 2-byte CRC. It checks the CRC and, when the check passes, presents the payload with a one-cycle valid strobe to the motor-control and echo logic. Error and timeout events are pulsed and counted for debug readout.

Parameters:
PAYLOAD_BYTES, 2, number of payload bytes between the magic word and the CRC (1..16).
MAGIC, 32'hDABBAD00, frame sync word; byte 0 on the wire is MAGIC[31:24].
TIMEOUT_CYCLES, 4096, idle clocks allowed between bytes inside a frame before the frame is abandoned.

Ports:
CLK  in  1  system clock (16 MHz)
reset  in  1  synchronous, active-high reset
rx_data_ready  in  1  one-cycle strobe from uart_rx: rx_data is valid
rx_data  in  8  received byte
frame_valid  out  1  one-cycle pulse: frame_payload updated with a CRC-good frame
frame_payload  out  8*PAYLOAD_BYTES  payload; first received byte in the MSBs
crc_error  out  1  one-cycle pulse: complete frame received, CRC mismatch
timeout_error  out  1  one-cycle pulse: frame abandoned on inter-byte timeout
in_frame  out  1  high from magic match until frame end or abort
frames_ok  out  16  count of good frames, wraps at 0xFFFF -> 0
frames_bad  out  16  count of CRC errors plus timeouts, saturates at 0xFFFF

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high. While reset is high, all state clears and rx_data_ready is ignored.
- Reset values: all outputs 0, frame_payload 0, state HUNT, window and fill count 0.
- CRC: CRC-16, polynomial x^16+x^15+x^2+1 (0x8005), init 0xFFFF, MSB-first per byte, no reflection, no final XOR. It covers the 4 magic bytes and the payload bytes in wire order. The transmitted CRC is high byte first, then low byte.
- The running CRC is updated bytewise in one cycle per byte (8-step combinational unroll). On magic match it loads the constant CRC(MAGIC, init 0xFFFF), computed at elaboration.
- HUNT state:
  - Each rx byte shifts into a 32-bit window; fill count saturates at 4.
  - A match requires fill==4 and {window[23:0], rx_data}==MAGIC in the same cycle. On match: go to PAYLOAD, set in_frame=1, byte index=0.
  - Overlapping/sliding matches must be found (e.g. DA DA BB AD 00 matches).
- PAYLOAD state: each byte goes into a staging buffer at the index position and updates the CRC. After PAYLOAD_BYTES bytes, go to CRC_HI.
- CRC_HI: store the byte and go to CRC_LO.
- CRC_LO: on the byte, compare {hi, lo} with the running CRC.
  - Match: on the next cycle frame_payload <= staging buffer, frame_valid=1, frames_ok+1.
  - Mismatch: on the next cycle crc_error=1, frames_bad+1, frame_payload unchanged.
  - Either way: return to HUNT with window and fill count cleared and in_frame=0 on that same cycle.
- Latency: frame_valid/crc_error assert exactly 1 cycle after the rx_data_ready of the last CRC byte.
- Timeout:
  - The idle counter resets on every rx_data_ready and counts only while not in HUNT.
  - When it reaches TIMEOUT_CYCLES, the next cycle gives timeout_error=1, frames_bad+1, HUNT, window cleared, in_frame=0.
  - If a byte and the timeout occur in the same cycle, the byte wins and no timeout is raised.
- frame_payload holds its value between good frames; it never shows partial data.
- Reset mid-frame: the frame is dropped silently, no error pulse, and counters clear.
- Back-to-back frames: a magic byte may arrive on the cycle after the last CRC byte; no dead cycles are required between frames.

Test Plan:
1. Good frame: bytes DA BB AD 00 12 34 followed by the model CRC (hi, lo) -> frame_valid for 1 cycle, 1 cycle after the last byte; frame_payload=16'h1234; frames_ok=1; in_frame low on that cycle.
2. Corrupted CRC: same frame with the CRC low byte XOR 0x01 -> crc_error pulse, frames_bad=1, frame_payload keeps its previous value (16'h1234), no frame_valid.
3. Sliding sync: garbage 00 DA DA BB AD 00 AB CD + CRC -> a single frame_valid with payload 16'hABCD.
4. Timeout: DA BB AD 00 12, then no bytes for 4096 clocks -> timeout_error on the next cycle, frames_bad increments. A subsequent good frame with payload 56 78 is then accepted.
5. Back-to-back: 3 good frames with no idle gap (payloads 0001, 0002, 0003) -> 3 frame_valid pulses, frames_ok=3. Then force frames_ok to 0xFFFF and send one more good frame -> frames_ok wraps to 0.
6. Reset mid-frame: reset asserted after DA BB AD 00 12 -> no pulses and all outputs 0. The remaining byte 34 and CRC are ignored; the next full good frame is decoded correctly.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Receive-side framer for the uart_rx byte stream. It hunts for the magic word,
// collects the payload and CRC-16, and pulses frame_valid or an error per frame.
module uart_frame_decoder #(
    parameter int          PAYLOAD_BYTES  = 2,
    parameter logic [31:0] MAGIC          = 32'hDABBAD00,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         rx_data_ready,
    input  logic [7:0]                   rx_data,
    output logic                         frame_valid,
    output logic [8*PAYLOAD_BYTES-1:0]   frame_payload,
    output logic                         crc_error,
    output logic                         timeout_error,
    output logic                         in_frame,
    output logic [15:0]                  frames_ok,
    output logic [15:0]                  frames_bad
);

    localparam int SW    = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    // CRC-16/0x8005, MSB first, one byte unrolled into eight shift steps.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    localparam logic [15:0] CRC_MAGIC =
        crc16_upd(crc16_upd(crc16_upd(crc16_upd(16'hFFFF, MAGIC[31:24]),
                                      MAGIC[23:16]), MAGIC[15:8]), MAGIC[7:0]);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO} state_t;

    state_t            state_q, state_d;
    logic [23:0]       window_q, window_d;
    logic [2:0]        fill_q, fill_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SW-1:0]     staging_q, staging_d;
    logic [15:0]       crc_q, crc_d;
    logic [7:0]        crc_hi_q, crc_hi_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic [SW-1:0]     frame_payload_q, frame_payload_d;
    logic              frame_valid_q, frame_valid_d;
    logic              crc_error_q, crc_error_d;
    logic              timeout_error_q, timeout_error_d;
    logic              in_frame_q, in_frame_d;
    logic [15:0]       frames_ok_q, frames_ok_d;
    logic [15:0]       frames_bad_q, frames_bad_d;

    always_comb begin
        state_d         = state_q;
        window_d        = window_q;
        fill_d          = fill_q;
        idx_d           = idx_q;
        staging_d       = staging_q;
        crc_d           = crc_q;
        crc_hi_d        = crc_hi_q;
        idle_d          = idle_q;
        frame_payload_d = frame_payload_q;
        frame_valid_d   = 1'b0;
        crc_error_d     = 1'b0;
        timeout_error_d = 1'b0;
        in_frame_d      = in_frame_q;
        frames_ok_d     = frames_ok_q;
        frames_bad_d    = frames_bad_q;

        if (rx_data_ready) begin
            idle_d = '0;
            unique case (state_q)
                HUNT: begin
                    window_d = {window_q[15:0], rx_data};
                    fill_d   = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                    // The current byte completes the window, so three prior bytes suffice.
                    if (fill_q >= 3'd3 && {window_q, rx_data} == MAGIC) begin
                        state_d    = PAYLOAD;
                        in_frame_d = 1'b1;
                        idx_d      = '0;
                        crc_d      = CRC_MAGIC;
                    end
                end
                PAYLOAD: begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (idx_q == IDX_W'(i)) staging_d[8*(PAYLOAD_BYTES-1-i) +: 8] = rx_data;
                    end
                    crc_d = crc16_upd(crc_q, rx_data);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = CRC_HI;
                end
                CRC_HI: begin
                    crc_hi_d = rx_data;
                    state_d  = CRC_LO;
                end
                CRC_LO: begin
                    if ({crc_hi_q, rx_data} == crc_q) begin
                        frame_payload_d = staging_q;
                        frame_valid_d   = 1'b1;
                        frames_ok_d     = frames_ok_q + 16'd1;
                    end else begin
                        crc_error_d  = 1'b1;
                        frames_bad_d = sat_inc(frames_bad_q);
                    end
                    state_d    = HUNT;
                    window_d   = '0;
                    fill_d     = '0;
                    in_frame_d = 1'b0;
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            if (idle_q == TO_LIMIT) begin
                timeout_error_d = 1'b1;
                frames_bad_d    = sat_inc(frames_bad_q);
                state_d         = HUNT;
                window_d        = '0;
                fill_d          = '0;
                in_frame_d      = 1'b0;
                idle_d          = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= HUNT;
            window_q        <= '0;
            fill_q          <= '0;
            idx_q           <= '0;
            staging_q       <= '0;
            crc_q           <= '0;
            crc_hi_q        <= '0;
            idle_q          <= '0;
            frame_payload_q <= '0;
            frame_valid_q   <= 1'b0;
            crc_error_q     <= 1'b0;
            timeout_error_q <= 1'b0;
            in_frame_q      <= 1'b0;
            frames_ok_q     <= '0;
            frames_bad_q    <= '0;
        end else begin
            state_q         <= state_d;
            window_q        <= window_d;
            fill_q          <= fill_d;
            idx_q           <= idx_d;
            staging_q       <= staging_d;
            crc_q           <= crc_d;
            crc_hi_q        <= crc_hi_d;
            idle_q          <= idle_d;
            frame_payload_q <= frame_payload_d;
            frame_valid_q   <= frame_valid_d;
            crc_error_q     <= crc_error_d;
            timeout_error_q <= timeout_error_d;
            in_frame_q      <= in_frame_d;
            frames_ok_q     <= frames_ok_d;
            frames_bad_q    <= frames_bad_d;
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_payload = frame_payload_q;
    assign crc_error     = crc_error_q;
    assign timeout_error = timeout_error_q;
    assign in_frame      = in_frame_q;
    assign frames_ok     = frames_ok_q;
    assign frames_bad    = frames_bad_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: a scoreboard of expected frame events
// is filled as frames are driven and drained by a monitor sampling after each edge.
module tb_uart_frame_decoder;

    logic        CLK;
    logic        reset;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        frame_valid;
    logic [15:0] frame_payload;
    logic        crc_error;
    logic        timeout_error;
    logic        in_frame;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    uart_frame_decoder #(
        .PAYLOAD_BYTES (2),
        .MAGIC         (32'hDABBAD00),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .rx_data_ready(rx_data_ready),
        .rx_data      (rx_data),
        .frame_valid  (frame_valid),
        .frame_payload(frame_payload),
        .crc_error    (crc_error),
        .timeout_error(timeout_error),
        .in_frame     (in_frame),
        .frames_ok    (frames_ok),
        .frames_bad   (frames_bad)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  flags;    // {timeout, crc_error, frame_valid}
        logic [15:0] payload;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] model_payload = 16'h0000;
    logic [15:0] exp_ok  = 16'h0000;
    logic [15:0] exp_bad = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int j = 7; j >= 0; j--) begin
                if (c[15] ^ b[i][j]) c = (c << 1) ^ 16'h8005;
                else                 c = c << 1;
            end
        end
        return c;
    endfunction

    // Monitor: each pulse must match the oldest expected event, on its due cycle.
    logic [2:0] obs_flags;
    exp_t       got;
    always @(posedge CLK) begin
        #1;
        cyc++;
        obs_flags = {timeout_error, crc_error, frame_valid};
        if (obs_flags != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, obs_flags}, 32'd0);
            end else begin
                got = sb.pop_front();
                chk("pulse_kind", {29'd0, obs_flags}, {29'd0, got.flags});
                chk("pulse_cycle", cyc, got.due);
                chk("pulse_payload", {16'd0, frame_payload}, {16'd0, got.payload});
            end
        end
    end

    task automatic drive(input logic [7:0] b);
        @(negedge CLK);
        rx_data_ready = 1'b1;
        rx_data       = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            rx_data_ready = 1'b0;
        end
    endtask

    task automatic expect_event(input logic [2:0] flags, input int due);
        exp_t e;
        e.flags   = flags;
        e.payload = model_payload;
        e.due     = due;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [15:0] pl, input logic [7:0] crc_xor);
        logic [7:0]  b[$];
        logic [15:0] c;
        b = {8'hDA, 8'hBB, 8'hAD, 8'h00, pl[15:8], pl[7:0]};
        c = crc_model(b);
        foreach (b[i]) begin
            drive(b[i]);
            if (i == 4) chk("in_frame_mid", {31'd0, in_frame}, 32'd1);
        end
        drive(c[15:8]);
        drive(c[7:0] ^ crc_xor);
        if (crc_xor == 8'h00) begin
            model_payload = pl;
            exp_ok        = exp_ok + 16'd1;
            expect_event(3'b001, cyc + 1);
        end else begin
            if (exp_bad != 16'hFFFF) exp_bad = exp_bad + 16'd1;
            expect_event(3'b010, cyc + 1);
        end
    endtask

    task automatic check_after_frame(input string tag);
        chk({tag, "_in_frame"}, {31'd0, in_frame}, 32'd0);
        chk({tag, "_frames_ok"}, {16'd0, frames_ok}, {16'd0, exp_ok});
        chk({tag, "_frames_bad"}, {16'd0, frames_bad}, {16'd0, exp_bad});
        chk({tag, "_payload"}, {16'd0, frame_payload}, {16'd0, model_payload});
    endtask

    initial begin
        logic [7:0]  rb[$];
        logic [15:0] rc;

        reset         = 1'b1;
        rx_data_ready = 1'b0;
        rx_data       = 8'h00;
        idle(3);
        chk("reset_outputs", {frame_valid, crc_error, timeout_error, in_frame, frame_payload},
            32'd0);
        chk("reset_counters", {frames_ok, frames_bad}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Good frame
        send_frame(16'h1234, 8'h00);
        idle(1);
        check_after_frame("good");

        // Corrupted CRC low byte
        idle(3);
        send_frame(16'h5555, 8'h01);
        idle(1);
        check_after_frame("crcbad");

        // Sliding sync through garbage and a repeated first magic byte
        idle(2);
        drive(8'h00);
        drive(8'hDA);
        send_frame(16'hABCD, 8'h00);
        idle(1);
        check_after_frame("slide");

        // Inter-byte timeout mid-payload
        idle(2);
        drive(8'hDA); drive(8'hBB); drive(8'hAD); drive(8'h00); drive(8'h12);
        if (exp_bad != 16'hFFFF) exp_bad = exp_bad + 16'd1;
        expect_event(3'b100, cyc + 1 + 4097);
        idle(4200);
        check_after_frame("timeout");
        send_frame(16'h5678, 8'h00);
        idle(1);
        check_after_frame("after_timeout");

        // Back-to-back frames with no idle gap
        idle(2);
        send_frame(16'h0001, 8'h00);
        send_frame(16'h0002, 8'h00);
        send_frame(16'h0003, 8'h00);
        idle(1);
        check_after_frame("b2b");

        // Good-frame counter wrap
        @(negedge CLK);
        force dut.frames_ok_d = 16'hFFFF;
        @(negedge CLK);
        release dut.frames_ok_d;
        exp_ok = 16'hFFFF;
        chk("ok_preset", {16'd0, frames_ok}, 32'h0000FFFF);
        send_frame(16'h4242, 8'h00);
        idle(1);
        chk("ok_wrap", {16'd0, frames_ok}, 32'd0);
        check_after_frame("wrap");

        // Reset in the middle of a frame
        idle(2);
        drive(8'hDA); drive(8'hBB); drive(8'hAD); drive(8'h00); drive(8'h12);
        @(negedge CLK);
        rx_data_ready = 1'b0;
        reset         = 1'b1;
        idle(2);
        model_payload = 16'h0000;
        exp_ok        = 16'h0000;
        exp_bad       = 16'h0000;
        chk("midreset_outputs", {frame_valid, crc_error, timeout_error, in_frame, frame_payload},
            32'd0);
        chk("midreset_counters", {frames_ok, frames_bad}, 32'd0);
        reset = 1'b0;
        rb = {8'hDA, 8'hBB, 8'hAD, 8'h00, 8'h12, 8'h34};
        rc = crc_model(rb);
        drive(8'h34);
        drive(rc[15:8]);
        drive(rc[7:0]);
        idle(2);
        check_after_frame("midreset_tail");
        send_frame(16'h9ABC, 8'h00);
        idle(1);
        check_after_frame("midreset_next");

        idle(5);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
